// File: rtl/reduction_requant_packer.sv
// Requantises TILE_SIZE signed accumulator lanes (rounding shift, optional ReLU,
// signed saturation) and packs them into one word, buffered in a FWFT FIFO.
// The upstream never stalls: a vector arriving at a full FIFO is dropped and flagged.
module reduction_requant_packer #(
    parameter int TILE_SIZE   = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              vec_valid,
    input  logic signed [ACC_WIDTH-1:0]       vec_in [TILE_SIZE],
    input  logic [SHIFT_WIDTH-1:0]            cfg_shift,
    input  logic                              cfg_relu,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [TILE_SIZE*OUT_WIDTH-1:0]    out_data,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    output logic [15:0]                       sat_count
);

    localparam int TW = ACC_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = TILE_SIZE * OUT_WIDTH;
    localparam int NW = $clog2(TILE_SIZE + 1);
    localparam logic signed [TW-1:0] SAT_MAX = TW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

    logic                   s1_valid;
    logic signed [TW-1:0]   s1_t [TILE_SIZE];
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic                   s1_relu;

    logic                   s2_valid;
    logic [WW-1:0]          s2_word;

    logic [TW-1:0]          round_bias;
    logic signed [TW-1:0]   t_next [TILE_SIZE];
    logic signed [TW-1:0]   y [TILE_SIZE];
    logic [WW-1:0]          word_next;
    logic [NW-1:0]          sat_lanes;
    logic [16:0]            sat_sum;

    logic [WW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [WW-1:0]          last_data;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // Rounding bias added one bit wider than the lane so the sum can never wrap.
    always_comb begin
        round_bias = '0;
        if (cfg_shift != '0)
            round_bias = TW'(1) << (cfg_shift - 1'b1);
        for (int i = 0; i < TILE_SIZE; i++)
            t_next[i] = $signed({vec_in[i][ACC_WIDTH-1], vec_in[i]}) + $signed(round_bias);
    end

    // Stage 1: capture biased lanes with the shift/relu settings that came with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++)
                s1_t[i] <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= vec_valid;
            if (vec_valid) begin
                s1_shift <= cfg_shift;
                s1_relu  <= cfg_relu;
                for (int i = 0; i < TILE_SIZE; i++)
                    s1_t[i] <= t_next[i];
            end
        end
    end

    // Arithmetic shift, ReLU, then clamp; only clamping counts as saturation.
    always_comb begin
        word_next = '0;
        sat_lanes = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            y[i] = s1_t[i] >>> s1_shift;
            if (s1_relu && (y[i] < 0))
                y[i] = '0;
            if (y[i] > SAT_MAX) begin
                word_next[i*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
                sat_lanes = sat_lanes + NW'(1);
            end else if (y[i] < SAT_MIN) begin
                word_next[i*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
                sat_lanes = sat_lanes + NW'(1);
            end else begin
                word_next[i*OUT_WIDTH +: OUT_WIDTH] = y[i][OUT_WIDTH-1:0];
            end
        end
    end

    assign sat_sum = {1'b0, sat_count} + 17'(sat_lanes);

    // Stage 2: hold the packed word for the FIFO write and accumulate saturations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_word   <= '0;
            sat_count <= '0;
        end else if (clear) begin
            s2_valid  <= 1'b0;
            sat_count <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word   <= word_next;
                sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : last_data;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = s2_valid && ((fifo_count < CW'(FIFO_DEPTH)) || pop);
    assign drop      = s2_valid && !push;

    // FIFO storage, pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            last_data  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s2_word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                last_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PW'(1);
            end
            if (drop)
                overflow <= 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
        end
    end

endmodule

// File: tb/tb_reduction_requant_packer.sv
// Bench for reduction_requant_packer: directed cases plus randomised traffic
// compared every cycle against an arithmetic reference with a queue-based FIFO.
module tb_reduction_requant_packer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic               vec_valid = 1'b0;
    logic signed [31:0] vec_in [4];
    logic [4:0]         cfg_shift = '0;
    logic               cfg_relu = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        out_data;
    logic [2:0]         fifo_count;
    logic               overflow;
    logic [15:0]        sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    bit [31:0] mq[$];
    bit        p1_v, p2_v;
    bit [31:0] p1_w, p2_w;
    int        p1_n;
    int        exp_sat;
    bit        exp_ovf;
    bit [31:0] exp_last;

    always #5 clk = ~clk;

    reduction_requant_packer dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .vec_valid  (vec_valid),
        .vec_in     (vec_in),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .sat_count  (sat_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requantise the vector currently on the inputs with plain integer arithmetic.
    function automatic void ref_vec(output bit [31:0] w, output int nsat);
        longint x, t, y;
        int s;
        w = '0;
        nsat = 0;
        s = int'(cfg_shift);
        for (int i = 0; i < 4; i++) begin
            x = longint'(vec_in[i]);
            t = (s == 0) ? x : x + (longint'(1) <<< (s - 1));
            y = t >>> s;
            if (cfg_relu && y < 0) y = 0;
            if (y > 127) begin
                y = 127;
                nsat++;
            end else if (y < -128) begin
                y = -128;
                nsat++;
            end
            w[i*8 +: 8] = y[7:0];
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        p1_v = 0; p2_v = 0; p1_w = 0; p2_w = 0; p1_n = 0;
        exp_sat = 0; exp_ovf = 0; exp_last = 0;
    endfunction

    // A vector sampled at edge k is counted at k+1 and offered to the FIFO at k+2.
    function automatic void model_edge();
        bit popped;
        int sz;
        if (clear) begin
            mq.delete();
            p1_v = 0; p2_v = 0;
            exp_ovf = 0; exp_sat = 0;
        end else begin
            sz = mq.size();
            popped = (sz > 0) && out_ready;
            if (popped) exp_last = mq.pop_front();
            if (p2_v) begin
                if (sz < 4 || popped) mq.push_back(p2_w);
                else exp_ovf = 1;
            end
            if (p1_v) exp_sat = (exp_sat + p1_n > 65535) ? 65535 : exp_sat + p1_n;
            p2_v = p1_v;
            p2_w = p1_w;
            p1_v = vec_valid;
            if (vec_valid) ref_vec(p1_w, p1_n);
        end
    endfunction

    task automatic check_all();
        check("out_valid", out_valid, (mq.size() != 0));
        check("fifo_count", fifo_count, mq.size());
        check("overflow", overflow, exp_ovf);
        check("sat_count", sat_count, exp_sat);
        check("out_data", out_data, (mq.size() != 0) ? mq[0] : exp_last);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic int rnd_lane();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 600)) - 300;
            1: return int'($urandom);
            2: return ($urandom_range(0, 1) == 0) ? 32'sh7FFFFFFF : 32'sh80000000;
            default: return int'($urandom_range(0, 70000)) - 35000;
        endcase
    endfunction

    task automatic set_vec(input int a, input int b, input int c, input int d);
        vec_in[0] = a; vec_in[1] = b; vec_in[2] = c; vec_in[3] = d;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 4; i++) vec_in[i] = rnd_lane();
        cfg_shift = 5'($urandom_range(0, 31));
        cfg_relu  = 1'($urandom_range(0, 1));
    endtask

    task automatic send_one(input int a, input int b, input int c, input int d,
                            input int sh, input bit rl, input bit [31:0] ew, input int esat);
        set_vec(a, b, c, d);
        cfg_shift = 5'(sh);
        cfg_relu  = rl;
        vec_valid = 1'b1;
        out_ready = 1'b1;
        step();
        vec_valid = 1'b0;
        step();
        step();
        check("dir_data", out_data, ew);
        check("dir_sat", sat_count, esat);
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        set_vec(0, 0, 0, 0);
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        check_all();

        // rounding, saturation, relu, boundary lanes
        send_one(100, -100, 8, 5000, 4, 1'b0, 32'h7F01FA06, 1);
        send_one(100, -100, 8, 5000, 4, 1'b1, 32'h7F010006, 2);
        send_one(127, -128, 128, -129, 0, 1'b0, 32'h807F807F, 4);

        // overflow: six back-to-back vectors into a stalled FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_vec();
            vec_valid = 1'b1;
            step();
        end
        vec_valid = 1'b0;
        step();
        step();
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("drain_empty", out_valid, 0);

        // full FIFO, simultaneous push and pop every cycle
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            rand_vec();
            vec_valid = 1'b1;
            if (i == 6) out_ready = 1'b1;
            step();
            if (i >= 6) begin
                check("full_count", fifo_count, 4);
                check("full_ovf", overflow, 0);
            end
        end
        vec_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // async reset with three entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_vec();
            vec_valid = 1'b1;
            step();
        end
        vec_valid = 1'b0;
        step();
        step();
        check("pre_rst_count", fifo_count, 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_sat", sat_count, 0);
        #1;
        rst = 1'b0;

        // clear while a vector sits in stage 1
        out_ready = 1'b1;
        set_vec(1000, 2000, -3000, 4000);
        cfg_shift = 5'd3;
        vec_valid = 1'b1;
        step();
        vec_valid = 1'b0;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            step();
            check("clr_s1_gone", out_valid, 0);
        end

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            rand_vec();
            vec_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 49) == 0);
            step();
        end
        clear = 1'b0;
        vec_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // sat_count sticks at its maximum
        do_clear();
        set_vec(5000, -5000, 5000, -5000);
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        vec_valid = 1'b1;
        for (int i = 0; i < 16400; i++) step();
        vec_valid = 1'b0;
        step();
        step();
        check("sat_sticky", sat_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
